// File: rtl/conv_engine_param_if.sv
// conv_engine_param_if: frame handshake and packed data/weight/result bus for conv_engine_param
interface conv_engine_param_if #(
    parameter int IMG_H  = 8,
    parameter int IMG_W  = 8,
    parameter int K      = 3,
    parameter int C_OUT  = 3,
    parameter int DW     = 8,
    parameter int STRIDE = 1
);
    localparam int OH = (IMG_H - K) / STRIDE + 1;
    localparam int OW = (IMG_W - K) / STRIDE + 1;
    logic                          in_vld;
    logic                          in_rdy;
    logic [IMG_H*IMG_W*DW-1:0]     data_lin;
    logic [C_OUT*K*K*DW-1:0]       weight_lin;
    logic                          out_vld;
    logic                          out_rdy;
    logic [C_OUT*OH*OW*DW-1:0]     conv_lin;
    logic                          busy;
    modport master (
        output in_vld, data_lin, weight_lin, out_rdy,
        input  in_rdy, out_vld, conv_lin, busy
    );
    modport slave (
        input  in_vld, data_lin, weight_lin, out_rdy,
        output in_rdy, out_vld, conv_lin, busy
    );
endinterface

// File: rtl/conv_engine_param.sv
// conv_engine_param: multi-channel 2D convolution, one kernel tap per channel per cycle
module conv_engine_param #(
    parameter int IMG_H  = 8,
    parameter int IMG_W  = 8,
    parameter int K      = 3,
    parameter int C_OUT  = 3,
    parameter int DW     = 8,
    parameter int STRIDE = 1,
    parameter int SHIFT  = 0
) (
    input logic clk,
    input logic rst_n,
    conv_engine_param_if.slave bus
);
    localparam int OH = (IMG_H - K) / STRIDE + 1;
    localparam int OW = (IMG_W - K) / STRIDE + 1;
    localparam int AW = 2 * DW + $clog2(K * K);
    localparam int CW = 16;
    localparam logic [CW-1:0] KL = CW'(K - 1);
    localparam logic [CW-1:0] OHL = CW'(OH - 1);
    localparam logic [CW-1:0] OWL = CW'(OW - 1);
    localparam logic signed [AW-1:0] SMAX = AW'(2 ** (DW - 1) - 1);
    localparam logic signed [AW-1:0] SMIN = ~SMAX;
    typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} state_t;
    state_t                    state;
    logic [IMG_H*IMG_W*DW-1:0] data_q;
    logic [C_OUT*K*K*DW-1:0]   weight_q;
    logic [CW-1:0]             r, c, i, j;
    logic signed [AW-1:0]      acc [C_OUT];
    logic signed [AW-1:0]      nxt [C_OUT];
    logic signed [AW-1:0]      sh  [C_OUT];
    logic signed [DW-1:0]      res [C_OUT];
    int                        pix_idx, out_idx;
    assign bus.in_rdy  = state == IDLE;
    assign bus.busy    = state == MAC || state == STORE;
    assign bus.out_vld = state == DONE;
    always_comb begin
        pix_idx = (int'(r) * STRIDE + int'(i)) * IMG_W + int'(c) * STRIDE + int'(j);
        out_idx = int'(r) * OW + int'(c);
        for (int ch = 0; ch < C_OUT; ch++) begin
            nxt[ch] = acc[ch] + AW'($signed(data_q[pix_idx*DW +: DW]) *
                      $signed(weight_q[(ch*K*K + int'(i)*K + int'(j))*DW +: DW]));
            sh[ch]  = acc[ch] >>> SHIFT;
            res[ch] = sh[ch] > SMAX ? SMAX[DW-1:0] : sh[ch] < SMIN ? SMIN[DW-1:0] : sh[ch][DW-1:0];
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            data_q       <= '0;
            weight_q     <= '0;
            r            <= '0;
            c            <= '0;
            i            <= '0;
            j            <= '0;
            acc          <= '{default: '0};
            bus.conv_lin <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_vld) begin
                    data_q   <= bus.data_lin;
                    weight_q <= bus.weight_lin;
                    r        <= '0;
                    c        <= '0;
                    i        <= '0;
                    j        <= '0;
                    acc      <= '{default: '0};
                    state    <= MAC;
                end
                MAC: begin
                    acc <= nxt;
                    j   <= j == KL ? '0 : j + 1'b1;
                    if (j == KL) i <= i == KL ? '0 : i + 1'b1;
                    if (i == KL && j == KL) state <= STORE;
                end
                STORE: begin
                    for (int ch = 0; ch < C_OUT; ch++)
                        bus.conv_lin[(ch*OH*OW + out_idx)*DW +: DW] <= res[ch];
                    acc   <= '{default: '0};
                    c     <= c == OWL ? '0 : c + 1'b1;
                    if (c == OWL) r <= r == OHL ? '0 : r + 1'b1;
                    state <= c == OWL && r == OHL ? DONE : MAC;
                end
                DONE: if (bus.out_rdy) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_engine_param.sv
// tb_conv_engine_param: table vectors, corner-case sequences and random frames against a reference model
module tb_conv_engine_param;
    logic clk = 0;
    logic rst_n = 0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;

    conv_engine_param_if a_if();
    conv_engine_param_if b_if();
    conv_engine_param_if #(.IMG_H(9), .IMG_W(9), .STRIDE(2)) c_if();
    conv_engine_param dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    conv_engine_param #(.SHIFT(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
    conv_engine_param #(.IMG_H(9), .IMG_W(9), .STRIDE(2)) dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

    typedef struct {
        string name;
        int    pix;
        int    w0, w1, w2;
        bit    centre2;
        int    e0, e1, e2;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [1023:0] pack(input int q[$]);
        pack = '0;
        foreach (q[n]) pack[n*8 +: 8] = 8'(q[n]);
    endfunction

    function automatic void rnd(input int n, output int q[$]);
        q = {};
        repeat (n) q.push_back(int'($urandom_range(255)) - 128);
    endfunction

    // Plain convolution over the spec rules, results in (ch,r,c) slot order
    function automatic void model(input int h, input int wd, input int k, input int st, input int sh,
                                  input int d[$], input int wt[$], output int res[$]);
        int oh, ow, s;
        oh = (h - k) / st + 1;
        ow = (wd - k) / st + 1;
        res = {};
        for (int ch = 0; ch < 3; ch++)
            for (int y = 0; y < oh; y++)
                for (int x = 0; x < ow; x++) begin
                    s = 0;
                    for (int p = 0; p < k; p++)
                        for (int q = 0; q < k; q++)
                            s += d[(y*st + p)*wd + x*st + q] * wt[(ch*k + p)*k + q];
                    s = s >>> sh;
                    if (s > 127) s = 127;
                    if (s < -128) s = -128;
                    res.push_back(s);
                end
    endfunction

    task automatic set_vld(input int sel, input logic v);
        if (sel == 0) a_if.in_vld = v;
        else if (sel == 1) b_if.in_vld = v;
        else c_if.in_vld = v;
    endtask

    task automatic drive(input int sel, input logic v, input int d[$], input int w[$]);
        logic [1023:0] dp, wp;
        dp = pack(d);
        wp = pack(w);
        set_vld(sel, v);
        if (sel == 0) begin
            a_if.data_lin = dp[511:0];
            a_if.weight_lin = wp[215:0];
        end else if (sel == 1) begin
            b_if.data_lin = dp[511:0];
            b_if.weight_lin = wp[215:0];
        end else begin
            c_if.data_lin = dp[647:0];
            c_if.weight_lin = wp[215:0];
        end
    endtask

    function automatic logic ovld(input int sel);
        return sel == 0 ? a_if.out_vld : sel == 1 ? b_if.out_vld : c_if.out_vld;
    endfunction

    function automatic logic [1023:0] conv(input int sel);
        return sel == 0 ? 1024'(a_if.conv_lin) : sel == 1 ? 1024'(b_if.conv_lin) : 1024'(c_if.conv_lin);
    endfunction

    task automatic wait_done(input int sel, output int lat);
        lat = 0;
        while (!ovld(sel) && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
        end
        check("out_vld_seen", int'(ovld(sel)), 1);
    endtask

    task automatic run_frame(input int sel, input int d[$], input int w[$], output int lat,
                             output logic [1023:0] res);
        drive(sel, 1'b1, d, w);
        @(posedge clk); #1;
        set_vld(sel, 1'b0);
        wait_done(sel, lat);
        res = conv(sel);
        @(posedge clk); #1;
    endtask

    task automatic cmp(input string name, input logic [1023:0] got, input int exp[$]);
        foreach (exp[n]) check($sformatf("%s[%0d]", name, n), int'($signed(got[n*8 +: 8])), exp[n]);
    endtask

    initial begin
        vec_t vecs[5];
        int d[$], w[$], alt_d[$], alt_w[$], exp[$];
        int lat, t0, pulses, period;
        logic [1023:0] res, snap;
        vecs = '{
            '{"ones",    1,    1,    2,   -1, 1'b1,    9,   18,   -1},
            '{"pos_sat", 127,  127,  127,  127, 1'b0,  127,  127,  127},
            '{"neg_sat", 127, -128, -128, -128, 1'b0, -128, -128, -128},
            '{"mixed",   3,   -2,    5,    0, 1'b0,  -54,  127,    0},
            '{"neg_pix", -1,   7,  -14,    1, 1'b1,  -63,  126,   -1}
        };
        d = {};
        w = {};
        drive(0, 1'b0, d, w);
        drive(1, 1'b0, d, w);
        drive(2, 1'b0, d, w);
        a_if.out_rdy = 1'b1;
        b_if.out_rdy = 1'b1;
        c_if.out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_rdy", int'(a_if.in_rdy), 1);
        check("rst_busy", int'(a_if.busy), 0);
        check("rst_out_vld", int'(a_if.out_vld), 0);
        check("rst_conv_zero", int'(a_if.conv_lin == '0), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[v]) begin
            d = {};
            w = {};
            exp = {};
            repeat (64) d.push_back(vecs[v].pix);
            for (int t = 0; t < 9; t++) w.push_back(vecs[v].w0);
            for (int t = 0; t < 9; t++) w.push_back(vecs[v].w1);
            for (int t = 0; t < 9; t++) w.push_back(vecs[v].centre2 ? (t == 4 ? vecs[v].w2 : 0) : vecs[v].w2);
            repeat (36) exp.push_back(vecs[v].e0);
            repeat (36) exp.push_back(vecs[v].e1);
            repeat (36) exp.push_back(vecs[v].e2);
            run_frame(0, d, w, lat, res);
            check({vecs[v].name, "_latency"}, lat, 360);
            cmp(vecs[v].name, res, exp);
        end

        repeat (4) begin
            rnd(64, d);
            rnd(27, w);
            model(8, 8, 3, 1, 0, d, w, exp);
            run_frame(0, d, w, lat, res);
            check("rand_a_latency", lat, 360);
            cmp("rand_a", res, exp);
        end

        // Consumer stalls for 5 cycles; result and flags must hold
        a_if.out_rdy = 1'b0;
        rnd(64, d);
        rnd(27, w);
        model(8, 8, 3, 1, 0, d, w, exp);
        drive(0, 1'b1, d, w);
        @(posedge clk); #1;
        set_vld(0, 1'b0);
        wait_done(0, lat);
        check("hold_latency", lat, 360);
        snap = conv(0);
        cmp("hold_res", snap, exp);
        repeat (5) begin
            @(posedge clk); #1;
            check("hold_out_vld", int'(a_if.out_vld), 1);
            check("hold_conv_stable", int'(conv(0) == snap), 1);
            check("hold_in_rdy", int'(a_if.in_rdy), 0);
        end
        a_if.out_rdy = 1'b1;
        @(posedge clk); #1;
        check("release_in_rdy", int'(a_if.in_rdy), 1);
        check("release_out_vld", int'(a_if.out_vld), 0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_conv_stable", int'(conv(0) == snap), 1);

        // in_vld toggling with junk data while the engine is working
        rnd(64, d);
        rnd(27, w);
        model(8, 8, 3, 1, 0, d, w, exp);
        drive(0, 1'b1, d, w);
        @(posedge clk); #1;
        lat = 0;
        while (!a_if.out_vld && lat < 3000) begin
            rnd(64, alt_d);
            rnd(27, alt_w);
            drive(0, lat[0], alt_d, alt_w);
            @(posedge clk); #1;
            lat++;
            if (lat == 5) begin
                check("mac_busy", int'(a_if.busy), 1);
                check("mac_in_rdy", int'(a_if.in_rdy), 0);
                check("mac_out_vld", int'(a_if.out_vld), 0);
                check("pre_store_conv_stable", int'(conv(0) == snap), 1);
            end
        end
        set_vld(0, 1'b0);
        check("toggle_out_vld_seen", int'(a_if.out_vld), 1);
        check("toggle_latency", lat, 360);
        cmp("toggle_res", conv(0), exp);
        @(posedge clk); #1;

        // Reset in the middle of a frame
        rnd(64, d);
        rnd(27, w);
        drive(0, 1'b1, d, w);
        @(posedge clk); #1;
        set_vld(0, 1'b0);
        repeat (99) @(posedge clk);
        #1;
        check("pre_rst_busy", int'(a_if.busy), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_vld", int'(a_if.out_vld), 0);
        check("midrst_conv_zero", int'(a_if.conv_lin == '0), 1);
        check("midrst_in_rdy", int'(a_if.in_rdy), 1);
        check("midrst_busy", int'(a_if.busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rnd(64, d);
        rnd(27, w);
        model(8, 8, 3, 1, 0, d, w, exp);
        run_frame(0, d, w, lat, res);
        check("post_rst_latency", lat, 360);
        cmp("post_rst", res, exp);

        // Back-to-back frames with in_vld and out_rdy held high
        drive(0, 1'b1, d, w);
        pulses = 0;
        t0 = 0;
        period = 0;
        for (int t = 1; t < 1500 && pulses < 2; t++) begin
            @(posedge clk); #1;
            if (a_if.out_vld) begin
                pulses++;
                if (pulses == 1) t0 = t;
                else period = t - t0;
            end
        end
        set_vld(0, 1'b0);
        check("tput_pulses", pulses, 2);
        check("tput_period", period, 362);
        @(posedge clk); #1;
        check("tput_idle", int'(a_if.in_rdy), 1);

        // SHIFT=4 instance
        d = {};
        w = {};
        exp = {};
        repeat (64) d.push_back(1);
        repeat (27) w.push_back(16);
        repeat (108) exp.push_back(9);
        run_frame(1, d, w, lat, res);
        check("shift_latency", lat, 360);
        cmp("shift", res, exp);
        rnd(64, d);
        rnd(27, w);
        model(8, 8, 3, 1, 4, d, w, exp);
        run_frame(1, d, w, lat, res);
        cmp("shift_rand", res, exp);

        // 9x9 image, stride 2 instance
        repeat (2) begin
            rnd(81, d);
            rnd(27, w);
            model(9, 9, 3, 2, 0, d, w, exp);
            run_frame(2, d, w, lat, res);
            check("stride_latency", lat, 160);
            cmp("stride", res, exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
